// File: rtl/lfsr_seq_fsm.sv
// Microsequencer that steps a Fibonacci LFSR on the shared register-file/ALU
// datapath. Register map: r1=state, r2=step count, r3=feedback, r4=temp,
// r5=nsteps. Run parameters are latched at start; the datapath is steered
// only through the address/func/constant outputs and observed via isZero.
module lfsr_seq_fsm #(
  parameter int WIDTH = 32,
  parameter int NTAPS = 4,
  parameter int TAPW  = 5,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  input  logic [NTAPS*TAPW-1:0] taps,
  input  logic [NTAPS-1:0]      tap_en,
  input  logic [CNTW-1:0]       nsteps,
  input  logic                  isZero,
  output logic [3:0]            raddr1,
  output logic [3:0]            raddr2,
  output logic                  wen,
  output logic [3:0]            waddr,
  output logic                  wdsrc,
  output logic [3:0]            func,
  output logic [WIDTH-1:0]      constant,
  output logic                  busy,
  output logic                  done
);

  localparam int IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_OR    = 4'd3;
  localparam logic [3:0] FN_XOR   = 4'd4;
  localparam logic [3:0] FN_SHL   = 4'd5;
  localparam logic [3:0] FN_SHR   = 4'd6;
  localparam logic [3:0] FN_PASSB = 4'd7;

  localparam logic [3:0] R_STATE = 4'd1;
  localparam logic [3:0] R_CNT   = 4'd2;
  localparam logic [3:0] R_FB    = 4'd3;
  localparam logic [3:0] R_TMP   = 4'd4;
  localparam logic [3:0] R_N     = 4'd5;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT0  = 4'd1,
    S_INIT1  = 4'd2,
    S_INIT2  = 4'd3,
    S_CHK    = 4'd4,
    S_ACC0   = 4'd5,
    S_TAP_SH = 4'd6,
    S_TAP_X  = 4'd7,
    S_FB_AND = 4'd8,
    S_FB_SHL = 4'd9,
    S_ST_SHR = 4'd10,
    S_ST_OR  = 4'd11,
    S_INC    = 4'd12,
    S_DONE   = 4'd13
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [WIDTH-1:0]        seed_r;
  logic [NTAPS*TAPW-1:0]   taps_r;
  logic [NTAPS-1:0]        tap_en_r;
  logic [CNTW-1:0]         nsteps_r;
  logic [IDXW-1:0]         tap_idx_r, tap_idx_nxt_s;
  logic [IDXW:0]           first_tap_s, next_tap_s;

  // Lowest enabled tap index >= from; MSB of the result flags "found".
  // Scanning downward lets the lowest match overwrite higher ones.
  function automatic logic [IDXW:0] find_tap(input logic [NTAPS-1:0] mask, input int from);
    logic [IDXW:0] res;
    res = '0;
    for (int i = NTAPS - 1; i >= 0; i--) begin
      res = ((i >= from) && mask[i]) ? {1'b1, IDXW'(i)} : res;
    end
    return res;
  endfunction

  // State register and run-parameter capture (only when a start is accepted)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      seed_r    <= '0;
      taps_r    <= '0;
      tap_en_r  <= '0;
      nsteps_r  <= '0;
      tap_idx_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      tap_idx_r <= tap_idx_nxt_s;
      if ((state_r == S_IDLE) && start) begin
        seed_r   <= seed;
        taps_r   <= taps;
        tap_en_r <= tap_en;
        nsteps_r <= nsteps;
      end else begin
        seed_r   <= seed_r;
        taps_r   <= taps_r;
        tap_en_r <= tap_en_r;
        nsteps_r <= nsteps_r;
      end
    end
  end

  // Next-state and datapath control decode; idle values are the defaults
  always_comb begin
    state_nxt_s   = state_r;
    tap_idx_nxt_s = tap_idx_r;
    raddr1        = 4'd0;
    raddr2        = 4'd0;
    wen           = 1'b0;
    waddr         = 4'd0;
    wdsrc         = 1'b0;
    func          = 4'd0;
    constant      = '0;
    busy          = 1'b1;
    done          = 1'b0;
    first_tap_s   = find_tap(tap_en_r, 0);
    next_tap_s    = find_tap(tap_en_r, int'(tap_idx_r) + 1);
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt_s = S_INIT0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_INIT0: begin
        wen = 1'b1; waddr = R_STATE; func = FN_PASSB; constant = seed_r;
        state_nxt_s = S_INIT1;
      end
      S_INIT1: begin
        wen = 1'b1; waddr = R_CNT; func = FN_PASSB;
        state_nxt_s = S_INIT2;
      end
      S_INIT2: begin
        wen = 1'b1; waddr = R_N; func = FN_PASSB; constant = WIDTH'(nsteps_r);
        state_nxt_s = S_CHK;
      end
      S_CHK: begin
        func = FN_SUB; raddr1 = R_N; raddr2 = R_CNT; wdsrc = 1'b1;
        if (isZero) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ACC0;
        end
      end
      S_ACC0: begin
        wen = 1'b1; waddr = R_FB; func = FN_PASSB;
        if (first_tap_s[IDXW]) begin
          tap_idx_nxt_s = first_tap_s[IDXW-1:0];
          state_nxt_s   = S_TAP_SH;
        end else begin
          state_nxt_s   = S_FB_AND;
        end
      end
      S_TAP_SH: begin
        // Shift amounts >= WIDTH pass through; the ALU returns 0 for them.
        wen = 1'b1; waddr = R_TMP; raddr1 = R_STATE; func = FN_SHR;
        constant = WIDTH'(taps_r[int'(tap_idx_r)*TAPW +: TAPW]);
        state_nxt_s = S_TAP_X;
      end
      S_TAP_X: begin
        wen = 1'b1; waddr = R_FB; raddr1 = R_FB; raddr2 = R_TMP; wdsrc = 1'b1;
        func = FN_XOR;
        if (next_tap_s[IDXW]) begin
          tap_idx_nxt_s = next_tap_s[IDXW-1:0];
          state_nxt_s   = S_TAP_SH;
        end else begin
          state_nxt_s   = S_FB_AND;
        end
      end
      S_FB_AND: begin
        wen = 1'b1; waddr = R_FB; raddr1 = R_FB; func = FN_AND; constant = WIDTH'(1);
        state_nxt_s = S_FB_SHL;
      end
      S_FB_SHL: begin
        wen = 1'b1; waddr = R_FB; raddr1 = R_FB; func = FN_SHL;
        constant = WIDTH'(WIDTH - 1);
        state_nxt_s = S_ST_SHR;
      end
      S_ST_SHR: begin
        wen = 1'b1; waddr = R_STATE; raddr1 = R_STATE; func = FN_SHR;
        constant = WIDTH'(1);
        state_nxt_s = S_ST_OR;
      end
      S_ST_OR: begin
        wen = 1'b1; waddr = R_STATE; raddr1 = R_STATE; raddr2 = R_FB; wdsrc = 1'b1;
        func = FN_OR;
        state_nxt_s = S_INC;
      end
      S_INC: begin
        wen = 1'b1; waddr = R_CNT; raddr1 = R_CNT; func = FN_ADD; constant = WIDTH'(1);
        state_nxt_s = S_CHK;
      end
      S_DONE: begin
        done = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: begin
        busy = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lfsr_seq_fsm.sv
// Bench for lfsr_seq_fsm: a register-file/ALU datapath around the DUT,
// a step-level LFSR reference and a cycle-timing expectation per run.
module tb_lfsr_seq_fsm;

  localparam int W  = 16;
  localparam int NT = 4;
  localparam int TW = 5;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W-1:0]      seed;
  logic [NT*TW-1:0]  taps;
  logic [NT-1:0]     tap_en;
  logic [CW-1:0]     nsteps;
  logic              isZero;
  logic [3:0]        raddr1, raddr2, waddr, func;
  logic              wen, wdsrc, busy, done;
  logic [W-1:0]      constant;

  logic [W-1:0]      rf [16];
  int                wr_cnt [16];
  logic [W-1:0]      op_a, op_b, alu_res;

  int n_chk = 0;
  int n_err = 0;

  lfsr_seq_fsm #(.WIDTH(W), .NTAPS(NT), .TAPW(TW), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .taps(taps),
    .tap_en(tap_en), .nsteps(nsteps), .isZero(isZero),
    .raddr1(raddr1), .raddr2(raddr2), .wen(wen), .waddr(waddr),
    .wdsrc(wdsrc), .func(func), .constant(constant), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath ALU
  always_comb begin
    op_a = rf[raddr1];
    op_b = wdsrc ? rf[raddr2] : constant;
    case (func)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = op_a << op_b;
      4'd6: alu_res = op_a >> op_b;
      4'd7: alu_res = op_b;
      default: alu_res = '0;
    endcase
    isZero = (alu_res == '0);
  end

  // Register file write port with per-register write counters
  always @(posedge clk) begin
    if (wen) begin
      rf[waddr]     <= alu_res;
      wr_cnt[waddr] <= wr_cnt[waddr] + 1;
    end
  end

  function automatic logic [NT*TW-1:0] pack_taps(input int t0, input int t1, input int t2, input int t3);
    logic [NT*TW-1:0] p;
    p = '0;
    p[0*TW +: TW] = TW'(t0);
    p[1*TW +: TW] = TW'(t1);
    p[2*TW +: TW] = TW'(t2);
    p[3*TW +: TW] = TW'(t3);
    return p;
  endfunction

  // Step-level reference: new = (s>>1) | (parity of enabled (s>>tap) bit0) << (W-1)
  function automatic logic [W-1:0] lfsr_ref(input logic [W-1:0] s0, input logic [NT*TW-1:0] tp,
                                            input logic [NT-1:0] en, input int n);
    logic [W-1:0] s;
    logic         fb;
    s = s0;
    for (int j = 0; j < n; j++) begin
      fb = 1'b0;
      for (int i = 0; i < NT; i++) begin
        if (en[i]) fb = fb ^ (((s >> tp[i*TW +: TW]) & 16'h0001) != 16'h0000);
      end
      s = {fb, s[W-1:1]};
    end
    return s;
  endfunction

  function automatic int done_cycle(input logic [NT-1:0] en, input int n);
    return 5 + n * (7 + 2 * $countones(en));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One run: start accepted on the first posedge; cycle c is sampled at its negedge.
  task automatic run(input string nm, input logic [W-1:0] sd, input logic [NT*TW-1:0] tp,
                     input logic [NT-1:0] en, input int n, input int restart_cyc, input int rst_cyc);
    int d;
    logic [W-1:0] exp_r1;
    int w3;
    int ndone;
    bit aborted;
    d      = done_cycle(en, n);
    exp_r1 = lfsr_ref(sd, tp, en, n);
    w3     = wr_cnt[3];
    ndone  = 0;
    aborted = 1'b0;
    @(negedge clk);
    seed = sd; taps = tp; tap_en = en; nsteps = CW'(n); start = 1'b1;
    @(negedge clk);
    // Scramble inputs mid-run; the latched copies must be used.
    start = 1'b0; seed = ~sd; taps = ~tp; tap_en = ~en; nsteps = ~CW'(n);
    for (int c = 1; c <= d + 2; c++) begin
      if (c == rst_cyc) begin
        rst = 1'b0;
        #1;
        check({nm, " rst busy"}, {31'd0, busy}, 32'd0);
        check({nm, " rst done"}, {31'd0, done}, 32'd0);
        check({nm, " rst ctl"}, {18'd0, wen, wdsrc, raddr1, raddr2, waddr}, 32'd0);
        check({nm, " rst func/const"}, {12'd0, func, constant}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check({nm, " post-rst idle"}, {30'd0, busy, done}, 32'd0);
        end
        aborted = 1'b1;
        break;
      end
      check({nm, " busy"}, {31'd0, busy}, {31'd0, (c >= 1) && (c <= d)});
      check({nm, " done"}, {31'd0, done}, {31'd0, c == d});
      if (done) ndone++;
      if (c > d) check({nm, " idle wen"}, {31'd0, wen}, 32'd0);
      start = (c == restart_cyc);
      @(negedge clk);
    end
    start = 1'b0;
    if (!aborted) begin
      check({nm, " r1"}, {16'd0, rf[1]}, {16'd0, exp_r1});
      check({nm, " r2"}, {16'd0, rf[2]}, n);
      check({nm, " done count"}, ndone, 32'd1);
      if (n == 0) check({nm, " r3 untouched"}, wr_cnt[3] - w3, 32'd0);
    end
  endtask

  initial begin
    logic [NT*TW-1:0] t4;
    logic [NT*TW-1:0] tbig;
    t4   = pack_taps(0, 2, 3, 5);
    tbig = pack_taps(1, 20, 7, 31);
    rst = 1'b0; start = 1'b0; seed = '0; taps = '0; tap_en = '0; nsteps = '0;
    #12;
    check("reset busy/done", {30'd0, busy, done}, 32'd0);
    check("reset ctl", {18'd0, wen, wdsrc, raddr1, raddr2, waddr}, 32'd0);
    check("reset func/const", {12'd0, func, constant}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Hand-computed anchors for the reference model
    check("model ace1 x1", {16'd0, lfsr_ref(16'hACE1, t4, 4'b1111, 1)}, 32'h5670);
    check("model 8000 x3", {16'd0, lfsr_ref(16'h8000, t4, 4'b0000, 3)}, 32'h1000);
    check("model lat k4", done_cycle(4'b1111, 1), 32'd20);
    check("model lat k0", done_cycle(4'b0000, 3), 32'd26);

    run("ace1_n1",   16'hACE1, t4,   4'b1111, 1,   0, 0);
    run("ace1_n255", 16'hACE1, t4,   4'b1111, 255, 0, 0);
    run("n0",        16'h1234, t4,   4'b1111, 0,   0, 0);
    run("notaps",    16'h8000, t4,   4'b0000, 3,   0, 0);
    run("bigshift",  16'hBEEF, tbig, 4'b1011, 5,   8, 0);
    run("restart_done", 16'h00F1, t4, 4'b0101, 2, done_cycle(4'b0101, 2), 0);
    run("midrst",    16'h1357, t4,   4'b1111, 4,   0, 10);
    run("after_rst", 16'h1357, t4,   4'b1111, 4,   0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
